// File: rtl/alsu_pkg.sv
// Shared types for the ALSU result path.
//   alsu_rec_t  : one buffered result, {err, out}
//   buf_state_e : occupancy state of the result buffer
//   make_rec    : builds a record from raw ALSU outputs (err = any leds bit set)
package alsu_pkg;

  localparam int unsigned ALSU_OUT_W  = 6;
  localparam int unsigned ALSU_LEDS_W = 16;

  typedef struct packed {
    logic                  err;
    logic [ALSU_OUT_W-1:0] out;
  } alsu_rec_t;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } buf_state_e;

  function automatic alsu_rec_t make_rec(input logic [ALSU_OUT_W-1:0]  out_v,
                                         input logic [ALSU_LEDS_W-1:0] leds_v);
    alsu_rec_t r;
    r.err = |leds_v;
    r.out = out_v;
    return r;
  endfunction

endpackage

// File: rtl/alsu_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset (async, active-low)
//   inc : count up by one unless already at all-ones
//   clr : synchronous clear, wins over inc
//   cnt : current value
module alsu_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alsu_result_buffer.sv
// First-word-fall-through result FIFO behind the ALSU, with drop/error stats.
//   clk, reset (async, active-low)
//   in_valid/in_out/in_leds : ALSU result stream, no back-pressure
//   clr_stats               : synchronous clear of drop_cnt, err_cnt, overflow
//   out_valid/out_ready/out_data : consumer stream, out_data = {err, out}
//   count/full/empty        : occupancy
//   drop_cnt/err_cnt        : saturating statistics
//   overflow                : sticky drop indicator
module alsu_result_buffer
  import alsu_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [ALSU_OUT_W-1:0]    in_out,
  input  logic [ALSU_LEDS_W-1:0]   in_leds,
  input  logic                     clr_stats,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ALSU_OUT_W:0]      out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_LAST = OCC_W'(DEPTH - 1);

  alsu_rec_t        mem [DEPTH];
  alsu_rec_t        wr_rec;
  alsu_rec_t        last_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  buf_state_e       state_q;
  buf_state_e       state_d;
  logic             push;
  logic             pop;
  logic             drop;
  logic             err_inc;

  assign wr_rec  = make_rec(in_out, in_leds);
  assign pop     = out_valid && out_ready;
  assign push    = in_valid && (!full || pop);
  assign drop    = in_valid && full && !pop;
  assign err_inc = push && wr_rec.err;

  assign out_valid = (state_q != EMPTY);
  assign full      = (state_q == FULL);
  assign empty     = (state_q == EMPTY);

  // Head is read straight from storage; once drained, the last popped word
  // is held so out_data never shows stale or uninitialised memory.
  assign out_data = (state_q == EMPTY) ? last_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_rec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      last_q  <= '0;
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (push) state_d = PARTIAL;
      end
      PARTIAL: begin
        if (pop && !push && (count == OCC_ONE)) begin
          state_d = EMPTY;
        end else if (push && !pop && (count == OCC_LAST)) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (pop && !push) state_d = PARTIAL;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (clr_stats) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  alsu_sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (drop),
    .clr   (clr_stats),
    .cnt   (drop_cnt)
  );

  alsu_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .clr   (clr_stats),
    .cnt   (err_cnt)
  );

endmodule

// File: tb/tb_alsu_result_buffer.sv
module tb_alsu_result_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [5:0]  in_out;
  logic [15:0] in_leds;
  logic        clr_stats;
  logic        out_ready;

  logic        out_valid,   out_valid_s;
  logic [6:0]  out_data,    out_data_s;
  logic [3:0]  count,       count_s;
  logic        full,        full_s;
  logic        empty,       empty_s;
  logic [7:0]  drop_cnt;
  logic [7:0]  err_cnt;
  logic [1:0]  drop_cnt_s;
  logic [1:0]  err_cnt_s;
  logic        overflow,    overflow_s;

  always #5 clk = ~clk;

  alsu_result_buffer #(.DEPTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_out(in_out),
    .in_leds(in_leds), .clr_stats(clr_stats), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .count(count), .full(full),
    .empty(empty), .drop_cnt(drop_cnt), .err_cnt(err_cnt), .overflow(overflow)
  );

  // Same stimulus, narrow counters to reach saturation quickly.
  alsu_result_buffer #(.DEPTH(8), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_out(in_out),
    .in_leds(in_leds), .clr_stats(clr_stats), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s), .count(count_s), .full(full_s),
    .empty(empty_s), .drop_cnt(drop_cnt_s), .err_cnt(err_cnt_s), .overflow(overflow_s)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of stored words plus plain integer statistics.
  logic [6:0] mq[$];
  logic [6:0] m_last;
  int         m_drop, m_err, m_drop_s, m_err_s;
  bit         m_ovf;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = '0; m_drop = 0; m_err = 0; m_drop_s = 0; m_err_s = 0; m_ovf = 0;
  endtask

  task automatic model_edge(input bit iv, input logic [5:0] o, input logic [15:0] l,
                            input bit rdy, input bit clr);
    bit         p_pop, p_push, p_drop;
    logic [6:0] rec;
    p_pop  = (mq.size() > 0) && rdy;
    p_push = iv && ((mq.size() < DEPTH) || p_pop);
    p_drop = iv && !p_push;
    rec    = {(l != 16'h0), o};
    if (p_pop)  m_last = mq.pop_front();
    if (p_push) mq.push_back(rec);
    if (clr) begin
      m_drop = 0; m_drop_s = 0; m_err = 0; m_err_s = 0; m_ovf = 0;
    end else begin
      if (p_drop) begin
        m_drop   = (m_drop   < 255) ? m_drop + 1   : 255;
        m_drop_s = (m_drop_s < 3)   ? m_drop_s + 1 : 3;
        m_ovf    = 1;
      end
      if (p_push && rec[6]) begin
        m_err   = (m_err   < 255) ? m_err + 1   : 255;
        m_err_s = (m_err_s < 3)   ? m_err_s + 1 : 3;
      end
    end
  endtask

  task automatic check_model(input string tag);
    int         sz;
    logic [6:0] head;
    sz   = mq.size();
    head = (sz > 0) ? mq[0] : m_last;
    chk({tag, ".out_valid"}, int'(out_valid), int'(sz > 0));
    chk({tag, ".count"},     int'(count),     sz);
    chk({tag, ".full"},      int'(full),      int'(sz == DEPTH));
    chk({tag, ".empty"},     int'(empty),     int'(sz == 0));
    chk({tag, ".out_data"},  int'(out_data),  int'(head));
    chk({tag, ".drop_cnt"},  int'(drop_cnt),  m_drop);
    chk({tag, ".err_cnt"},   int'(err_cnt),   m_err);
    chk({tag, ".overflow"},  int'(overflow),  int'(m_ovf));
    chk({tag, ".drop_cnt_s"}, int'(drop_cnt_s), m_drop_s);
    chk({tag, ".err_cnt_s"},  int'(err_cnt_s),  m_err_s);
    chk({tag, ".out_data_s"}, int'(out_data_s), int'(head));
  endtask

  // Drive inputs for one cycle, advance the model at the edge, sample #1 later.
  task automatic cycle(input string tag, input bit iv, input logic [5:0] o,
                       input logic [15:0] l, input bit rdy, input bit clr);
    in_valid = iv; in_out = o; in_leds = l; out_ready = rdy; clr_stats = clr;
    @(posedge clk);
    model_edge(iv, o, l, rdy, clr);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    bit          iv;
    logic [5:0]  o;
    logic [15:0] l;
    bit          rdy;
    bit          clr;
    bit          e_valid;
    logic [6:0]  e_data;
    int          e_count;
    int          e_err;
  } vec_t;

  vec_t       tbl [7];
  logic [6:0] got [DEPTH];

  initial begin
    tbl[0] = '{1'b1, 6'h15, 16'h0000, 1'b1, 1'b0, 1'b1, 7'h15, 1, 0}; // no bypass
    tbl[1] = '{1'b0, 6'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 7'h15, 0, 0}; // pop, hold last
    tbl[2] = '{1'b1, 6'h2A, 16'hA5A5, 1'b0, 1'b0, 1'b1, 7'h6A, 1, 1}; // err flag
    tbl[3] = '{1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 7'h6A, 1, 1}; // stall stable
    tbl[4] = '{1'b1, 6'h01, 16'h0001, 1'b1, 1'b0, 1'b1, 7'h41, 1, 2}; // push+pop
    tbl[5] = '{1'b0, 6'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 7'h41, 0, 2}; // drain
    tbl[6] = '{1'b0, 6'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 7'h41, 0, 2}; // ready on empty

    reset = 1'b0; in_valid = 0; in_out = '0; in_leds = '0; out_ready = 0; clr_stats = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.empty",     int'(empty),     1);
    chk("rst.full",      int'(full),      0);
    chk("rst.count",     int'(count),     0);
    chk("rst.out_data",  int'(out_data),  0);
    chk("rst.drop_cnt",  int'(drop_cnt),  0);
    chk("rst.err_cnt",   int'(err_cnt),   0);
    chk("rst.overflow",  int'(overflow),  0);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      cycle($sformatf("tbl%0d", i), tbl[i].iv, tbl[i].o, tbl[i].l, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d.valid", i), int'(out_valid), int'(tbl[i].e_valid));
      chk($sformatf("tbl%0d.data", i),  int'(out_data),  int'(tbl[i].e_data));
      chk($sformatf("tbl%0d.count", i), int'(count),     tbl[i].e_count);
      chk($sformatf("tbl%0d.err", i),   int'(err_cnt),   tbl[i].e_err);
    end

    // Fill and overflow: 10 pushes, no consumer
    for (int i = 0; i < 10; i++) cycle("fill", 1'b1, 6'(i + 1), 16'h0, 1'b0, 1'b0);
    chk("ovf.full",     int'(full),       1);
    chk("ovf.count",    int'(count),      8);
    chk("ovf.drop_cnt", int'(drop_cnt),   2);
    chk("ovf.overflow", int'(overflow),   1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain.order", int'(out_data), i + 1);
      cycle("drain", 1'b0, 6'h0, 16'h0, 1'b1, 1'b0);
    end
    chk("drain.empty", int'(empty), 1);

    // Push and pop at full
    for (int i = 0; i < DEPTH; i++) cycle("fill2", 1'b1, 6'(8'h10 + i), 16'h0, 1'b0, 1'b0);
    cycle("fullpp", 1'b1, 6'h3F, 16'h0, 1'b1, 1'b0);
    chk("fullpp.count",    int'(count),    8);
    chk("fullpp.drop_cnt", int'(drop_cnt), 2);
    for (int i = 0; i < DEPTH; i++) begin
      got[i] = out_data;
      cycle("drain2", 1'b0, 6'h0, 16'h0, 1'b1, 1'b0);
    end
    chk("fullpp.first", int'(got[0]), 8'h11);
    chk("fullpp.eighth", int'(got[7]), 8'h3F);

    // Saturation (2-bit counters) and clear-wins-over-increment
    for (int i = 0; i < DEPTH; i++) cycle("fill3", 1'b1, 6'(i), 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle("drop5", 1'b1, 6'h2, 16'h0, 1'b0, 1'b0);
    chk("sat.drop_cnt_s", int'(drop_cnt_s), 3);
    chk("sat.drop_cnt",   int'(drop_cnt),   7);
    cycle("clrdrop", 1'b1, 6'h2, 16'h1, 1'b0, 1'b1);
    chk("clr.drop_cnt",   int'(drop_cnt),   0);
    chk("clr.drop_cnt_s", int'(drop_cnt_s), 0);
    chk("clr.overflow",   int'(overflow),   0);
    chk("clr.count",      int'(count),      8);
    for (int i = 0; i < DEPTH; i++) cycle("drain3", 1'b0, 6'h0, 16'h0, 1'b1, 1'b0);

    // Asynchronous reset with 3 entries held
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 6'(i + 5), 16'h00F0, 1'b0, 1'b0);
    in_valid = 0; out_ready = 0;
    #2 reset = 1'b0;
    #1;
    chk("arst.out_valid", int'(out_valid), 0);
    chk("arst.count",     int'(count),     0);
    chk("arst.empty",     int'(empty),     1);
    chk("arst.drop_cnt",  int'(drop_cnt),  0);
    chk("arst.err_cnt",   int'(err_cnt),   0);
    chk("arst.out_data",  int'(out_data),  0);
    model_reset();
    reset = 1'b1;

    // Randomized traffic against the model, consumer speed varies per block
    for (int blk = 0; blk < 15; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(10, 95);
      for (int c = 0; c < 200; c++) begin
        bit          iv, rdy, clr;
        logic [5:0]  o;
        logic [15:0] l;
        iv  = ($urandom_range(0, 99) < 70);
        o   = 6'($urandom);
        l   = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0;
        rdy = ($urandom_range(0, 99) < rdy_pct);
        clr = ($urandom_range(0, 149) == 0);
        cycle("rand", iv, o, l, rdy, clr);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alsu_result_buffer.md
Name: alsu_result_buffer

Overview:
Downstream stage of the ALSU. Captures each ALSU result (6-bit out plus 16-bit leds) into a first-word-fall-through FIFO and presents it to the consumer over a valid/ready stream. Keeps saturating statistics: results dropped on overflow, and results taken while leds was non-zero (error/status indication). The ALSU has no back-pressure, so this block absorbs rate mismatch between the ALSU and a slower consumer (scoreboard, UART packer, etc.).

Parameters:
DEPTH, 8, number of FIFO entries; power of two, >= 2
CNT_W, 8, width of drop_cnt and err_cnt statistics counters

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset; 0 = reset asserted
in_valid  input  1  ALSU result present this cycle
in_out  input  6  ALSU out value
in_leds  input  16  ALSU leds value
clr_stats  input  1  synchronous clear of drop_cnt, err_cnt, overflow
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts head entry
out_data  output  7  {err, out[5:0]} of head entry
count  output  $clog2(DEPTH)+1  current occupancy
full  output  1  count == DEPTH
empty  output  1  count == 0
drop_cnt  output  CNT_W  saturating count of dropped results
err_cnt  output  CNT_W  saturating count of accepted results with err=1
overflow  output  1  sticky: at least one drop since reset/clr_stats

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr, rd_ptr, count, drop_cnt, err_cnt, overflow = 0; out_valid=0, empty=1, full=0; out_data = 0. Memory contents not reset; unread entries are discarded.
- Entry format: err = |in_leds; stored word = {err, in_out}.
- Push: push = in_valid && (!full || pop). Pop: pop = out_valid && out_ready.
- Push at full with a simultaneous pop is accepted; count unchanged, pointers both advance.
- Drop: in_valid && full && !pop -> entry discarded, drop_cnt increments (saturates at 2^CNT_W-1), overflow set.
- err_cnt increments on every accepted push with err=1; saturates at 2^CNT_W-1.
- Latency: entry pushed at edge N is on out_data with out_valid=1 after edge N (visible cycle N+1). Empty FIFO with push and out_ready=1 does not bypass; the entry still appears the next cycle.
- out_data equals the head entry whenever out_valid=1. When empty it holds the last popped value (0 after reset). It must remain stable while out_valid && !out_ready.
- Occupancy state machine: EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH). Transitions:
  - EMPTY->PARTIAL on push.
  - PARTIAL->EMPTY on pop with no push at count=1.
  - PARTIAL->FULL on push with no pop at count=DEPTH-1.
  - FULL->PARTIAL on pop with no push.
  - All other push/pop combinations: no state change.
  - out_valid = !EMPTY, full = FULL, empty = EMPTY; all registered.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- clr_stats: next drop_cnt = err_cnt = 0, overflow = 0. Clear wins over a same-cycle increment. FIFO contents and pointers are unaffected.
- out_ready while empty: ignored, no state change.
- X on in_out/in_leds while in_valid=0: must not affect any state.

Decomposition:
- Package alsu_pkg:
  - typedef alsu_rec_t packed struct {logic err; logic [5:0] out;}
  - typedef enum {EMPTY, PARTIAL, FULL} buf_state_e
  - constant ALSU_OUT_W = 6
  - constant ALSU_LEDS_W = 16
- Sub-module: alsu_sat_counter (parameter W; inputs inc, clr; clr priority; saturating), instantiated twice for drop_cnt and err_cnt.

Test Plan:
- Reset then idle: reset=0 mid-stream with 3 entries held -> out_valid=0, count=0, empty=1, drop_cnt=0 immediately, before the next clk edge.
- Single pass: push in_out=6'h15, in_leds=16'h0 with out_ready=1 -> next cycle out_valid=1, out_data=7'h15, then empty.
- Error flag: push in_out=6'h2A, in_leds=16'hA5A5 -> out_data=7'h6A, err_cnt=1.
- Fill and overflow, DEPTH=8, out_ready=0: 10 consecutive pushes -> full=1, count=8, drop_cnt=2, overflow=1. Then drain with out_ready=1 -> first 8 values in order, then empty.
- Full with simultaneous push/pop: at count=8, in_valid=1 and out_ready=1 -> count stays 8, no drop, new entry emerges 8th in order.
- Saturation and clear, CNT_W=2: 5 drops -> drop_cnt=3. clr_stats asserted in the same cycle as a drop -> drop_cnt=0, overflow=0.
